lsu: RTL and testbench

- Load/store unit on the CPU side of the data bus; it acts as the bus initiator toward the memory block (ROM/RAM/iodev decoder).
- Accepts one load/store request at a time from the execute stage.
- Drives `mem_addr`, one-hot `mem_write_enable` and `mem_wdata`, waits a configurable read latency, and samples `mem_rdata` (which arrives already right-shifted by the byte offset).
- Returns a sign- or zero-extended load result, or a fault, as a single-cycle response.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_if.sv | 46 ++++
 rtl/lsu_extend.sv | 24 ++
 rtl/lsu.sv | 154 +++++++++++++++
 tb/tb_lsu.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - size_e   : request size codes (byte / half / word / illegal)
//   - WE_*     : one-hot store strobe codes on the memory bus
//   - state_e  : LSU FSM state encoding (also exported as a debug output)
//   - is_aligned / we_code : small helpers used by the top level
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_X = 2'd3
    } size_e;

    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_WORD = 3'b001;
    localparam logic [2:0] WE_HALF = 3'b010;
    localparam logic [2:0] WE_BYTE = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACCESS     = 3'd1,
        ST_WAIT       = 3'd2,
        ST_SPLIT_NEXT = 3'd3,
        ST_RESP       = 3'd4
    } state_e;

    // Bytes are always aligned; halves need addr[0] = 0; words need addr[1:0] = 0.
    function automatic logic is_aligned(size_e size, logic [1:0] offset);
        case (size)
            SIZE_B:  return 1'b1;
            SIZE_H:  return ~offset[0];
            SIZE_W:  return offset == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] we_code(size_e size);
        case (size)
            SIZE_B:  return WE_BYTE;
            SIZE_H:  return WE_HALF;
            SIZE_W:  return WE_WORD;
            default: return WE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_req_if: execute-stage <-> LSU request/response channel.
//   master = execute stage, slave = LSU.
//   Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both 1; all req_* fields are captured on that edge and the
//   LSU ignores them afterwards. resp_valid is a one-cycle pulse with no
//   ready; resp_fault and resp_rdata are only meaningful while it is high.
// lsu_mem_if: LSU <-> memory decoder bus.
//   master = LSU, slave = memory. mem_rdata arrives already shifted right by
//   the byte offset of mem_addr.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

interface lsu_mem_if;
    logic [31:0] mem_addr;
    logic [2:0]  mem_write_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_write_enable, mem_wdata,
        input  mem_rdata
    );
    modport slave (
        input  mem_addr, mem_write_enable, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_extend.sv
// lsu_extend: combinational load-data formatter.
//   raw       : sampled (already offset-shifted or byte-assembled) load data
//   size      : access size; byte uses raw[7:0], half uses raw[15:0]
//   is_signed : 1 = sign-extend, 0 = zero-extend
//   result    : 32-bit extended value (word loads pass through)
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  size_e       size,
    input  logic        is_signed,
    output logic [31:0] result
);

    always_comb begin
        result = raw;
        case (size)
            SIZE_B:  result = {{24{is_signed & raw[7]}}, raw[7:0]};
            SIZE_H:  result = {{16{is_signed & raw[15]}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit, bus initiator toward the memory decoder.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   rq         : lsu_req_if.slave  - request/response from the execute stage
//   mb         : lsu_mem_if.master - memory bus (addr, one-hot strobe, data)
//   fsm_state  : current FSM state, for observation only
// Parameter:
//   MEM_LATENCY : extra cycles the address is held before mem_rdata is sampled
// Build option:
//   LSU_MISALIGNED_SPLIT_EN - when defined, misaligned half/word accesses are
//   split into sequential byte accesses; otherwise they fault with no bus cycle.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 0
)
(
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  rq,
    lsu_mem_if.master mb,
    output state_e    fsm_state
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

    state_e        state, state_next;
    logic [31:0]   addr_q, wdata_q, raw_q, ext_data;
    logic          write_q, signed_q, fault_q, split_q;
    size_e         size_q;
    logic [1:0]    idx_q;
    logic [CW-1:0] lat_q;

    size_e req_size_w;
    logic  accept, illegal, misaligned, sample, last_byte, bus_active;

    assign req_size_w = size_e'(rq.req_size);
    assign accept     = rq.req_valid && (state == ST_IDLE);
    assign illegal    = (req_size_w == SIZE_X);
    assign misaligned = !illegal && !is_aligned(req_size_w, rq.req_addr[1:0]);

    // Read data is taken on the last cycle the address is held: the ACCESS
    // cycle itself when there is no extra latency, else the last WAIT cycle.
    assign sample = ((state == ST_ACCESS) && (MEM_LATENCY == 0)) ||
                    ((state == ST_WAIT) && (lat_q == LAT_LAST));

    // A non-split access is its own last byte; a split one ends on byte 1 (half) or 3 (word).
    assign last_byte = !split_q || (idx_q == ((size_q == SIZE_H) ? 2'd1 : 2'd3));

    assign bus_active = (state == ST_ACCESS) || (state == ST_WAIT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal || (misaligned && !SPLIT_EN)) state_next = ST_RESP;
                    else                                      state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (MEM_LATENCY != 0) state_next = ST_WAIT;
                else                  state_next = last_byte ? ST_RESP : ST_SPLIT_NEXT;
            end
            ST_WAIT: begin
                if (sample) state_next = last_byte ? ST_RESP : ST_SPLIT_NEXT;
            end
            ST_SPLIT_NEXT: state_next = ST_ACCESS;
            ST_RESP:       state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // Request capture and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            raw_q    <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            fault_q  <= 1'b0;
            split_q  <= 1'b0;
            size_q   <= SIZE_B;
            idx_q    <= '0;
            lat_q    <= '0;
        end else begin
            if (accept) begin
                addr_q   <= rq.req_addr;
                wdata_q  <= rq.req_wdata;
                write_q  <= rq.req_write;
                signed_q <= rq.req_signed;
                size_q   <= req_size_w;
                fault_q  <= illegal || (misaligned && !SPLIT_EN);
                split_q  <= misaligned && SPLIT_EN;
                idx_q    <= '0;
                raw_q    <= '0;
            end
            if (state == ST_ACCESS) lat_q <= '0;
            if (state == ST_WAIT)   lat_q <= lat_q + 1'b1;
            if (sample) begin
                // Split loads gather one byte per access into its final lane.
                if (split_q) raw_q[{idx_q, 3'b000} +: 8] <= mb.mem_rdata[7:0];
                else         raw_q <= mb.mem_rdata;
            end
            if (state == ST_SPLIT_NEXT) begin
                addr_q <= addr_q + 32'd1;
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

    // Bus outputs: only driven while an access is in flight.
    always_comb begin
        mb.mem_addr         = '0;
        mb.mem_wdata        = '0;
        mb.mem_write_enable = WE_NONE;
        if (bus_active) begin
            mb.mem_addr  = addr_q;
            mb.mem_wdata = split_q ? {24'd0, wdata_q[{idx_q, 3'b000} +: 8]} : wdata_q;
        end
        // Strobe lasts exactly the ACCESS cycle so each store writes once.
        if ((state == ST_ACCESS) && write_q)
            mb.mem_write_enable = split_q ? WE_BYTE : we_code(size_q);
    end

    lsu_extend u_extend (
        .raw       (raw_q),
        .size      (size_q),
        .is_signed (signed_q),
        .result    (ext_data)
    );

    assign rq.req_ready  = (state == ST_IDLE);
    assign rq.resp_valid = (state == ST_RESP);
    assign rq.resp_fault = (state == ST_RESP) && fault_q;
    assign rq.resp_rdata = ((state == ST_RESP) && !fault_q && !write_q) ? ext_data : '0;
    assign fsm_state     = state;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: bench for lsu. dut0 (MEM_LATENCY = 0) runs a vector table against a
// byte-array memory; dut1 (MEM_LATENCY = 2) covers held-address latency and a
// reset issued during WAIT. Honours LSU_MISALIGNED_SPLIT_EN when defined.
module tb_lsu;
    import lsu_pkg::*;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset1 = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUTs ----------------
    lsu_req_if rq0();
    lsu_mem_if mb0();
    state_e    st0;
    lsu #(.MEM_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .rq(rq0), .mb(mb0), .fsm_state(st0)
    );

    lsu_req_if rq1();
    lsu_mem_if mb1();
    state_e    st1;
    lsu #(.MEM_LATENCY(2)) dut1 (
        .clk(clk), .reset(reset1), .rq(rq1), .mb(mb1), .fsm_state(st1)
    );

    // ---------------- memory models ----------------
    // dut0: byte memory; read data is the 4 bytes starting at the address.
    logic [7:0] mem0 [0:255];
    logic [7:0] a0;
    assign a0 = mb0.mem_addr[7:0];
    assign mb0.mem_rdata = {mem0[a0 + 8'd3], mem0[a0 + 8'd2], mem0[a0 + 8'd1], mem0[a0]};

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem0[i] <= 8'h00;
            mem0[0] <= 8'hFF;
            mem0[1] <= 8'hF0;
            mem0[2] <= 8'h80;
            mem0[3] <= 8'h00;
        end else begin
            case (mb0.mem_write_enable)
                WE_WORD: for (int i = 0; i < 4; i++) mem0[a0 + 8'(i)] <= mb0.mem_wdata[8*i +: 8];
                WE_HALF: for (int i = 0; i < 2; i++) mem0[a0 + 8'(i)] <= mb0.mem_wdata[8*i +: 8];
                WE_BYTE: mem0[a0] <= mb0.mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    // dut1: read data is a fixed function of the address, so a sample taken
    // while the address is not held gives a visibly different value.
    assign mb1.mem_rdata = mb1.mem_addr ^ 32'hA5A5_0000;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q [$];   // {fault, rdata}
    logic [32:0] exp_item;
    always @(negedge clk) begin
        if (rq0.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                exp_item = exp_q.pop_front();
                chk("resp", {rq0.resp_fault, rq0.resp_rdata}, exp_item);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        logic [2:0]  exp_we;
        int          exp_we_cyc;
        int          exp_bus;   // -1: bus-cycle count not checked
    } vec_t;

    vec_t        vecs [$];
    logic [63:0] strobe_log [$];   // {mem_addr, mem_wdata} per strobe cycle

    function automatic vec_t mk(logic w, logic [1:0] sz, logic s, logic [7:0] lo,
                                logic [31:0] wd, logic [31:0] er, logic ef,
                                int lat, logic [2:0] we, int wec, int bus);
        vec_t v;
        v.write = w; v.size = sz; v.sgn = s; v.addr = 32'h1000_0000 | {24'd0, lo};
        v.wdata = wd; v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = lat;
        v.exp_we = we; v.exp_we_cyc = wec; v.exp_bus = bus;
        return v;
    endfunction

    // ---------------- driver for dut0 ----------------
    task automatic run0(input vec_t v, input string tag);
        int lat, we_cnt, we_bad, bus_cnt;
        bit got;
        @(negedge clk);
        rq0.req_write  = v.write;
        rq0.req_size   = v.size;
        rq0.req_signed = v.sgn;
        rq0.req_addr   = v.addr;
        rq0.req_wdata  = v.wdata;
        rq0.req_valid  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rq0.req_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, "_accept"}, 64'(got), 64'd1);
        if (!got) begin
            rq0.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({v.exp_fault, v.exp_rdata});
        #1;
        // Scramble the request fields: the LSU must work from its captured copy.
        rq0.req_valid  = 1'b0;
        rq0.req_addr   = $urandom;
        rq0.req_wdata  = $urandom;
        rq0.req_size   = 2'($urandom_range(0, 3));
        rq0.req_write  = 1'($urandom_range(0, 1));
        rq0.req_signed = 1'($urandom_range(0, 1));
        strobe_log.delete();
        lat = 0; we_cnt = 0; we_bad = 0; bus_cnt = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (mb0.mem_addr != 32'd0) bus_cnt++;
            if (mb0.mem_write_enable != WE_NONE) begin
                we_cnt++;
                if (mb0.mem_write_enable != v.exp_we) we_bad++;
                strobe_log.push_back({mb0.mem_addr, mb0.mem_wdata});
            end
            if (rq0.resp_valid) begin got = 1'b1; break; end
        end
        chk({tag, "_resp_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, "_we_cycles"}, 64'(we_cnt), 64'(v.exp_we_cyc));
        chk({tag, "_we_code_bad"}, 64'(we_bad), 64'd0);
        if (v.exp_bus >= 0) chk({tag, "_bus_cycles"}, 64'(bus_cnt), 64'(v.exp_bus));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          lat, addr_cnt, ready_bad, we_bad, resp_cnt;
        bit          got;
        logic [31:0] rdata;
        vec_t        v;

        rq0.req_valid = 1'b0; rq0.req_write = 1'b0; rq0.req_size = 2'd0;
        rq0.req_signed = 1'b0; rq0.req_addr = '0; rq0.req_wdata = '0;
        rq1.req_valid = 1'b0; rq1.req_write = 1'b0; rq1.req_size = 2'd0;
        rq1.req_signed = 1'b0; rq1.req_addr = '0; rq1.req_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        reset1 = 1'b0;

        // Reset state
        chk("rst_state",   64'(st0), 64'(ST_IDLE));
        chk("rst_ready",   64'(rq0.req_ready), 64'd1);
        chk("rst_valid",   64'(rq0.resp_valid), 64'd0);
        chk("rst_fault",   64'(rq0.resp_fault), 64'd0);
        chk("rst_rdata",   64'(rq0.resp_rdata), 64'd0);
        chk("rst_addr",    64'(mb0.mem_addr), 64'd0);
        chk("rst_we",      64'(mb0.mem_write_enable), 64'd0);
        chk("rst_wdata",   64'(mb0.mem_wdata), 64'd0);

        // Table: memory starts with word 0x0080F0FF at offset 0, zeros elsewhere.
        vecs.push_back(mk(1, 2, 0, 8'h04, 32'hDEADBEEF, 32'h0, 0, 2, WE_WORD, 1, 1));
        vecs.push_back(mk(0, 2, 0, 8'h04, 32'h0, 32'hDEADBEEF, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 32'h0, 32'hFFFFFFFF, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'h0, 32'h000000FF, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 1, 1, 8'h02, 32'h0, 32'h00000080, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 32'h0, 32'h0000F0FF, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 1, 1, 8'h00, 32'h0, 32'hFFFFF0FF, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(1, 3, 0, 8'h08, 32'h12345678, 32'h0, 1, 1, WE_NONE, 0, 0));
        vecs.push_back(SPLIT ? mk(0, 1, 1, 8'h01, 32'h0, 32'hFFFF80F0, 0, 4, WE_NONE, 0, -1)
                             : mk(0, 1, 1, 8'h01, 32'h0, 32'h0, 1, 1, WE_NONE, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h08, 32'hAAAA1234, 32'h0, 0, 2, WE_HALF, 1, 1));
        vecs.push_back(mk(0, 2, 0, 8'h08, 32'h0, 32'h00001234, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h0B, 32'hFFFFFF55, 32'h0, 0, 2, WE_BYTE, 1, 1));
        vecs.push_back(mk(0, 2, 0, 8'h08, 32'h0, 32'h55001234, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h0B, 32'h0, 32'h00000055, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h02, 32'h0, 32'hFFFFFF80, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 2, 1, 8'h04, 32'h0, 32'hDEADBEEF, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 1, 0, 8'h06, 32'h0, 32'h0000DEAD, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(mk(0, 1, 1, 8'h06, 32'h0, 32'hFFFFDEAD, 0, 2, WE_NONE, 0, 1));
        vecs.push_back(SPLIT ? mk(0, 2, 0, 8'h02, 32'h0, 32'hBEEF0080, 0, 8, WE_NONE, 0, -1)
                             : mk(0, 2, 0, 8'h02, 32'h0, 32'h0, 1, 1, WE_NONE, 0, 0));
        vecs.push_back(SPLIT ? mk(1, 2, 0, 8'h0D, 32'h11223344, 32'h0, 0, 8, WE_BYTE, 4, -1)
                             : mk(1, 2, 0, 8'h0D, 32'h11223344, 32'h0, 1, 1, WE_NONE, 0, 0));
        vecs.push_back(mk(0, 2, 0, 8'h0C, 32'h0, SPLIT ? 32'h22334400 : 32'h0, 0, 2, WE_NONE, 0, 1));

        for (int i = 0; i < vecs.size(); i++) run0(vecs[i], $sformatf("v%0d", i));

        // Misaligned word store at 0x10000001, then read back.
        v = SPLIT ? mk(1, 2, 0, 8'h01, 32'h11223344, 32'h0, 0, 8, WE_BYTE, 4, -1)
                  : mk(1, 2, 0, 8'h01, 32'h11223344, 32'h0, 1, 1, WE_NONE, 0, 0);
        run0(v, "split_st");
        chk("split_st_strobes", 64'(strobe_log.size()), SPLIT ? 64'd4 : 64'd0);
        if (SPLIT && strobe_log.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("split_st_byte%0d", i), strobe_log[i],
                    {32'h1000_0001 + 32'(i), 24'd0, v.wdata[8*i +: 8]});
        end
        run0(mk(0, 2, 0, 8'h01, 32'h0, SPLIT ? 32'h11223344 : 32'h0,
                !SPLIT, SPLIT ? 8 : 1, WE_NONE, 0, SPLIT ? -1 : 0), "split_ld");

        // Latency with MEM_LATENCY = 2, req_valid held high.
        @(negedge clk);
        rq1.req_write = 1'b0; rq1.req_size = 2'd2; rq1.req_signed = 1'b0;
        rq1.req_addr = 32'h1000_0040; rq1.req_wdata = 32'h0; rq1.req_valid = 1'b1;
        chk("lat1_ready", 64'(rq1.req_ready), 64'd1);
        @(posedge clk);
        #1;
        lat = 0; addr_cnt = 0; ready_bad = 0; we_bad = 0; got = 1'b0; rdata = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (mb1.mem_addr == 32'h1000_0040) addr_cnt++;
            if (mb1.mem_write_enable != WE_NONE) we_bad++;
            if (rq1.req_ready) ready_bad++;
            if (rq1.resp_valid) begin got = 1'b1; rdata = rq1.resp_rdata; break; end
        end
        rq1.req_valid = 1'b0;
        chk("lat1_resp_seen",   64'(got), 64'd1);
        chk("lat1_latency",     64'(lat), 64'd4);
        chk("lat1_addr_cycles", 64'(addr_cnt), 64'd3);
        chk("lat1_ready_high",  64'(ready_bad), 64'd0);
        chk("lat1_strobes",     64'(we_bad), 64'd0);
        chk("lat1_rdata",       64'(rdata), 64'(32'h1000_0040 ^ 32'hA5A5_0000));

        // Reset while in WAIT abandons the request.
        @(negedge clk);
        rq1.req_addr = 32'h1000_0080; rq1.req_valid = 1'b1;
        chk("rmid_ready", 64'(rq1.req_ready), 64'd1);
        @(posedge clk);
        #1;
        rq1.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmid_in_wait", 64'(st1), 64'(ST_WAIT));
        reset1 = 1'b1;
        @(negedge clk);
        reset1 = 1'b0;
        chk("rmid_state", 64'(st1), 64'(ST_IDLE));
        chk("rmid_ready_after", 64'(rq1.req_ready), 64'd1);
        chk("rmid_no_valid", 64'(rq1.resp_valid), 64'd0);
        chk("rmid_mem_out", {mb1.mem_addr, mb1.mem_wdata}, 64'd0);
        chk("rmid_we", 64'(mb1.mem_write_enable), 64'd0);
        resp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rq1.resp_valid) resp_cnt++;
        end
        chk("rmid_no_late_resp", 64'(resp_cnt), 64'd0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
